mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
- Multicycle MIPS main controller. Sits directly upstream of the ALU and drives its 3-bit function select (f), operand-mux selects and all datapath enables, one instruction step per clock.
- Consumes the ALU zero flag to resolve branches.
- Waits on a memory-ready handshake during fetch, load and store, so it works with slow unified memory.

Parameters:
- none. Encodings are fixed by the ISA subset: lw, sw, R-type add/sub/and/or/slt, beq, addi, j.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- op  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag, same cycle
- memready  input  1  memory has completed the current access
- pcen  output  1  PC register enable
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register enable
- regwrite  output  1  register file write enable
- iord  output  1  memory address: 0=PC, 1=ALUOut
- memtoreg  output  1  write-back data: 0=ALUOut, 1=Data
- regdst  output  1  destination register: 0=rt, 1=rd
- alusrca  output  1  ALU a: 0=PC, 1=A register
- alusrcb  output  2  ALU b: 00=B, 01=constant 4, 10=SignImm, 11=SignImm<<2
- pcsrc  output  2  PC source: 00=ALU y, 01=ALUOut, 10=jump target
- alucontrol  output  3  ALU f: 010 add, 110 sub, 000 and, 001 or, 111 slt
- state  output  4  current state, for debug

Behaviour:
- Clocking and reset:
  - Reset is sampled on the rising clk edge and is synchronous, active-high.
  - On reset the state becomes FETCH (0).
  - While reset=1, pcen, memwrite, irwrite and regwrite are forced to 0.
  - Reset asserted mid-instruction abandons the instruction. The next cycle after reset deasserts is FETCH.
- Output timing:
  - Outputs are decoded combinationally from the state (Moore).
  - Exceptions: pcen depends on zero, and the FETCH enables depend on memready.
- Default values in every state unless listed below:
  - all 1-bit outputs = 0
  - alusrcb = 00
  - pcsrc = 00
  - alucontrol = 010
- State encodings and per-state outputs:
  - FETCH (0): iord=0, alusrca=0, alusrcb=01, add. irwrite=pcwrite=memready. Stay in FETCH while memready=0, else go to DECODE.
  - DECODE (1): alusrca=0, alusrcb=11, add (branch target into ALUOut).
    - lw/sw -> MEMADR
    - R-type -> RTYPEEX
    - beq -> BEQEX
    - addi -> ADDIEX
    - j -> JEX
    - any other op -> FETCH (treated as nop; PC already advanced)
  - MEMADR (2): alusrca=1, alusrcb=10, add. lw -> MEMRD, sw -> MEMWR.
  - MEMRD (3): iord=1. Hold while memready=0, else go to MEMWB.
  - MEMWB (4): regdst=0, memtoreg=1, regwrite=1. Go to FETCH.
  - MEMWR (5): iord=1, memwrite=1. memwrite stays asserted until memready=1, then go to FETCH.
  - RTYPEEX (6): alusrca=1, alusrcb=00, alucontrol decoded from funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - Valid funct -> RTYPEWB. Unknown funct -> FETCH with no register write.
  - RTYPEWB (7): regdst=1, memtoreg=0, regwrite=1. Go to FETCH.
  - BEQEX (8): alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1. Go to FETCH.
  - ADDIEX (9): alusrca=1, alusrcb=10, add. Go to ADDIWB.
  - ADDIWB (10): regdst=0, memtoreg=0, regwrite=1. Go to FETCH.
  - JEX (11): pcsrc=10, pcwrite=1. Go to FETCH.
  - Unused encodings (12-15) -> FETCH with all enables 0.
- PC enable: pcen = pcwrite | (branch & zero).
- Cycle counts with memready tied high:
  - lw = 5
  - sw, R-type, addi = 4
  - beq, j = 3
  - undecoded op = 2
  - Each memready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.

Optional Feature:
- Macro: MC_BNE_EN
- Defined:
  - op 000101 (bne) in DECODE -> BNEEX (12).
  - BNEEX drives the same outputs as BEQEX.
  - pcen = pcwrite | (branch & zero) | (branchn & ~zero).
  - BNEEX -> FETCH.
- Undefined:
  - bne is an unknown op (DECODE -> FETCH).
  - Encoding 12 is unused.
  - The branchn term is absent.

Test Plan:
- Reset 2 cycles mid-MEMRD, memready=1 -> state=0; pcen=irwrite=regwrite=memwrite=0 during reset; irwrite=pcen=1 in the first cycle after release.
- op=100011, memready=1 -> states 0,1,2,3,4,0. MEMWB: regwrite=1, memtoreg=1, regdst=0. MEMADR: alucontrol=010, alusrcb=10.
- op=101011, memready low for 3 cycles in MEMWR -> memwrite=1 and iord=1 for 4 cycles; regwrite stays 0; then FETCH.
- op=0, funct=101010 then 100010 -> alucontrol=111 then 110 in RTYPEEX; RTYPEWB regdst=1. funct=000011 -> RTYPEEX then FETCH with regwrite never 1.
- op=000100 with zero=1 -> pcen=1, pcsrc=01 in BEQEX. Repeat with zero=0 -> pcen=0. op=000010 -> JEX pcsrc=10, pcen=1.
- MC_BNE_EN defined, op=000101, zero=0 -> pcen=1 in state 12. Undefined -> DECODE -> FETCH and pcen=0.

Source files
------------

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS main controller; optional bne support under MC_BNE_EN
module mips_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  state_t     state_r;
  state_t     state_n;
  logic       pcwrite;
  logic       branch;
`ifdef MC_BNE_EN
  logic       branchn;
`endif
  logic [2:0] rtype_f;
  logic       rtype_ok;

  // R-type funct decode; unknown functs fall back to add and are flagged invalid
  always_comb begin
    rtype_ok = 1'b1;
    rtype_f  = ALU_ADD;
    case (funct)
      6'b100000: rtype_f = ALU_ADD;
      6'b100010: rtype_f = ALU_SUB;
      6'b100100: rtype_f = ALU_AND;
      6'b100101: rtype_f = ALU_OR;
      6'b101010: rtype_f = ALU_SLT;
      default: begin
        rtype_ok = 1'b0;
        rtype_f  = ALU_ADD;
      end
    endcase
  end

  // state register, reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_FETCH;
    else       state_r <= state_n;
  end

  assign state = state_r;

  // next-state and Moore outputs; pcen and fetch enables also see zero/memready
  always_comb begin
    state_n    = S_FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
`ifdef MC_BNE_EN
    branchn    = 1'b0;
`endif
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    case (state_r)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
        state_n = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_RTYPEEX;
          OP_BEQ:       state_n = S_BEQEX;
          OP_ADDI:      state_n = S_ADDIEX;
          OP_J:         state_n = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_n = S_BNEEX;
`endif
          default:      state_n = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_n = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_n  = memready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_f;
        state_n    = rtype_ok ? S_RTYPEWB : S_FETCH;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_n = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branchn    = 1'b1;
      end
`endif
      default: state_n = S_FETCH;
    endcase

`ifdef MC_BNE_EN
    pcen = pcwrite | (branch & zero) | (branchn & ~zero);
`else
    pcen = pcwrite | (branch & zero);
`endif

    if (reset) begin
      pcen     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - self-checking bench for mips_mc_controller against an instruction-step model
module tb_mips_mc_controller;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef int iq_t[$];

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic [14:0] dut_vec;

  int n_chk  = 0;
  int n_fail = 0;

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  assign dut_vec = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                    alusrcb, pcsrc, alucontrol};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU function for an R-type funct; -1 when the funct is not part of the subset
  function automatic int alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return -1;
    endcase
  endfunction

  // step list an instruction walks through after DECODE (empty means straight back to fetch)
  function automatic iq_t plan(input logic [5:0] o, input logic [5:0] fn);
    iq_t q;
    q = {};
    if (o == OP_LW)         q = {2, 3, 4};
    else if (o == OP_SW)    q = {2, 5};
    else if (o == OP_RTYPE) q = (alu_of(fn) >= 0) ? iq_t'({6, 7}) : iq_t'({6});
    else if (o == OP_BEQ)   q = {8};
    else if (o == OP_ADDI)  q = {9, 10};
    else if (o == OP_J)     q = {11};
`ifdef MC_BNE_EN
    else if (o == OP_BNE)   q = {12};
`endif
    return q;
  endfunction

  // expected output bundle for a step, from the per-step output table
  function automatic logic [14:0] exp_vec(input int st, input logic z, input logic mr,
                                          input logic rst, input logic [5:0] fn);
    logic pcw, br, bn, mw, irw, rw, io, m2r, rd, asa;
    logic [1:0] asb, psrc;
    logic [2:0] ac;
    int a;
    {pcw, br, bn, mw, irw, rw, io, m2r, rd, asa} = '0;
    asb = 2'd0; psrc = 2'd0; ac = 3'b010;
    case (st)
      0:  begin asb = 2'd1; irw = mr; pcw = mr; end
      1:  asb = 2'd3;
      2:  begin asa = 1'b1; asb = 2'd2; end
      3:  io = 1'b1;
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin io = 1'b1; mw = 1'b1; end
      6:  begin asa = 1'b1; a = alu_of(fn); if (a >= 0) ac = 3'(a); end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin asa = 1'b1; ac = 3'b110; psrc = 2'd1; br = 1'b1; end
      9:  begin asa = 1'b1; asb = 2'd2; end
      10: rw = 1'b1;
      11: begin psrc = 2'd2; pcw = 1'b1; end
      12: begin asa = 1'b1; ac = 3'b110; psrc = 2'd1; bn = 1'b1; end
      default: ;
    endcase
    if (rst) begin pcw = 0; br = 0; bn = 0; mw = 0; irw = 0; rw = 0; end
    return {pcw | (br & z) | (bn & ~z), mw, irw, rw, io, m2r, rd, asa, asb, psrc, ac};
  endfunction

  // reference model: current step of the instruction in flight
  int  cur    = 0;
  bit  mvalid = 1'b0;
  iq_t seq;

  // advance the model on each clock edge
  always @(posedge clk) begin
    if (reset) begin
      cur = 0; mvalid = 1'b1; seq = {};
    end else if (mvalid) begin
      if (cur == 0) begin
        if (memready) cur = 1;
      end else if (cur == 1) begin
        seq = plan(op, funct);
        cur = (seq.size() > 0) ? seq.pop_front() : 0;
      end else if ((cur == 3 || cur == 5) && !memready) begin
        cur = cur;
      end else begin
        cur = (seq.size() > 0) ? seq.pop_front() : 0;
      end
    end
  end

  // compare DUT against the model every cycle, away from the rising edge
  always @(negedge clk) begin
    logic [14:0] e;
    if (mvalid) begin
      e = exp_vec(cur, zero, memready, reset, funct);
      n_chk++;
      if (state !== 4'(cur)) begin
        n_fail++;
        $display("FAIL model_state t=%0t: got %0d expected %0d", $time, state, cur);
      end
      n_chk++;
      if (dut_vec !== e) begin
        n_fail++;
        $display("FAIL model_outputs t=%0t state=%0d: got %b expected %b", $time, cur, dut_vec, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic mr, input logic z);
    @(posedge clk);
    #1;
    reset = rst; memready = mr; zero = z;
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] rop;
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; memready = 1'b1;

    cyc(1, 1, 0);
    chk("rst_pcen", pcen, 0);
    chk("rst_irwrite", irwrite, 0);
    cyc(1, 1, 0);
    chk("rst_state", state, 0);
    cyc(0, 1, 0);
    chk("rel_irwrite", irwrite, 1);
    chk("rel_pcen", pcen, 1);

    op = OP_LW;
    cyc(0, 1, 0); chk("lw_s1", state, 1);
    cyc(0, 1, 0); chk("lw_s2", state, 2);
    chk("lw_memadr_alu", alucontrol, 3'b010);
    chk("lw_memadr_srcb", alusrcb, 2'b10);
    cyc(0, 1, 0); chk("lw_s3", state, 3);
    cyc(0, 1, 0); chk("lw_s4", state, 4);
    chk("lw_wb_regwrite", regwrite, 1);
    chk("lw_wb_memtoreg", memtoreg, 1);
    chk("lw_wb_regdst", regdst, 0);
    cyc(0, 1, 0); chk("lw_s0", state, 0);

    cyc(0, 1, 0); cyc(0, 1, 0);
    cyc(1, 1, 0);
    chk("rstmid_state", state, 3);
    chk("rstmid_pcen", pcen, 0);
    chk("rstmid_irwrite", irwrite, 0);
    chk("rstmid_regwrite", regwrite, 0);
    chk("rstmid_memwrite", memwrite, 0);
    cyc(1, 1, 0); chk("rstmid_to_fetch", state, 0);
    cyc(0, 1, 0);
    chk("rstmid_rel_irwrite", irwrite, 1);
    chk("rstmid_rel_pcen", pcen, 1);

    op = OP_SW;
    cyc(0, 1, 0); cyc(0, 1, 0); chk("sw_memadr", state, 2);
    for (int i = 0; i < 4; i++) begin
      cyc(0, (i == 3), 0);
      chk("sw_memwr_state", state, 5);
      chk("sw_memwrite", memwrite, 1);
      chk("sw_iord", iord, 1);
      chk("sw_regwrite", regwrite, 0);
    end
    cyc(0, 1, 0); chk("sw_done", state, 0);

    op = OP_RTYPE; funct = 6'b101010;
    cyc(0, 1, 0); cyc(0, 1, 0); chk("slt_alu", alucontrol, 3'b111);
    cyc(0, 1, 0); chk("slt_regdst", regdst, 1);
    cyc(0, 1, 0);
    funct = 6'b100010;
    cyc(0, 1, 0); cyc(0, 1, 0); chk("sub_alu", alucontrol, 3'b110);
    cyc(0, 1, 0); cyc(0, 1, 0);
    funct = 6'b000011;
    cyc(0, 1, 0); cyc(0, 1, 0); chk("badfn_state", state, 6);
    chk("badfn_regwrite", regwrite, 0);
    cyc(0, 1, 0); chk("badfn_fetch", state, 0);

    op = OP_BEQ;
    cyc(0, 1, 1); cyc(0, 1, 1);
    chk("beq_state", state, 8);
    chk("beq_taken_pcen", pcen, 1);
    chk("beq_pcsrc", pcsrc, 2'b01);
    cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    chk("beq_nt_pcen", pcen, 0);
    cyc(0, 1, 0);

    op = OP_J;
    cyc(0, 1, 0); cyc(0, 1, 0);
    chk("j_state", state, 11);
    chk("j_pcsrc", pcsrc, 2'b10);
    chk("j_pcen", pcen, 1);
    cyc(0, 1, 0);

    op = OP_ADDI;
    cyc(0, 1, 0); cyc(0, 1, 0); chk("addi_ex", state, 9);
    cyc(0, 1, 0); chk("addi_wb_regwrite", regwrite, 1);
    cyc(0, 1, 0); chk("addi_done", state, 0);

    op = OP_BNE;
    cyc(0, 1, 0); chk("bne_decode", state, 1);
    cyc(0, 0, 0);
`ifdef MC_BNE_EN
    chk("bne_state", state, 12);
    chk("bne_pcen", pcen, 1);
`else
    chk("bne_state", state, 0);
    chk("bne_pcen", pcen, 0);
`endif
    cyc(0, 1, 0);

    for (int n = 0; n < 3000; n++) begin
      if (cur == 0) begin
        case ($urandom_range(0, 7))
          0: op = OP_LW;
          1: op = OP_SW;
          2: op = OP_RTYPE;
          3: op = OP_BEQ;
          4: op = OP_ADDI;
          5: op = OP_J;
          6: op = OP_BNE;
          default: begin rop = 6'($urandom); op = rop; end
        endcase
        case ($urandom_range(0, 5))
          0: funct = 6'b100000;
          1: funct = 6'b100010;
          2: funct = 6'b100100;
          3: funct = 6'b100101;
          4: funct = 6'b101010;
          default: begin rop = 6'($urandom); funct = rop; end
        endcase
      end
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
